// File: rtl/sound_sequencer.sv
// sound_sequencer: arbitrates one-shot game sound effects over a looping
// soundtrack, drives the track ROM mux (select/adress) and hands one PCM
// sample to the codec per sample tick. The soundtrack resumes at the word
// where it was interrupted.
module sound_sequencer #(
  parameter int ROM_LATENCY    = 2,
  parameter int SOUNDTRACK_SEL = 5
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        sample_tick,
  input  logic        ev_player_hit,
  input  logic        ev_shot,
  input  logic        ev_invader,
  input  logic        ev_ufo,
  input  logic        music_en,
  output logic [3:0]  select,
  output logic [31:0] adress,
  input  logic [15:0] dout,
  input  logic [17:0] depth,
  input  logic [31:0] repeats,
  output logic [15:0] audio_out,
  output logic        audio_valid,
  output logic        busy
);

  localparam logic [3:0] ST_SEL  = 4'(SOUNDTRACK_SEL);
  localparam logic [7:0] LAT_CNT = 8'(ROM_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_READY  = 3'd2,
    S_SETTLE = 3'd3,
    S_END    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  select_q, select_d;
  logic [17:0] adr_q, adr_d;
  logic [17:0] saved_q, saved_d;
  logic [15:0] audio_q, audio_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        pend_q, pend_d;
  logic [17:0] depth_q, depth_d;
  logic        rep_q, rep_d;

  logic [3:0]  ev_code_s;
  logic [17:0] adr_inc_s;
  logic        playing_s;
  logic        preempt_s;

  // Arbitration rank of a select code; larger wins, silence ranks lowest.
  function automatic logic [2:0] prio_of(input logic [3:0] code);
    logic [2:0] p;
    case (code)
      4'd1:    p = 3'd5;
      4'd3:    p = 3'd4;
      4'd2:    p = 3'd3;
      4'd4:    p = 3'd2;
      default: p = (code == ST_SEL) ? 3'd1 : 3'd0;
    endcase
    return p;
  endfunction

  // Highest-priority event of this cycle; simultaneous lower ones are dropped.
  always_comb begin
    if (ev_player_hit) begin
      ev_code_s = 4'd1;
    end else if (ev_invader) begin
      ev_code_s = 4'd3;
    end else if (ev_shot) begin
      ev_code_s = 4'd2;
    end else if (ev_ufo) begin
      ev_code_s = 4'd4;
    end else begin
      ev_code_s = 4'd0;
    end
  end

  assign adr_inc_s = adr_q + 18'd1;
  assign playing_s = (state_q == S_START) || (state_q == S_READY) || (state_q == S_SETTLE);
  assign preempt_s = (ev_code_s != 4'd0) &&
                     ((prio_of(ev_code_s) > prio_of(select_q)) || (ev_code_s == select_q));

  // Next-state logic: normal track sequencing, then preemption / music-off overrides.
  always_comb begin
    state_d  = state_q;
    cnt_d    = 8'd0;
    select_d = select_q;
    adr_d    = adr_q;
    saved_d  = saved_q;
    audio_d  = audio_q;
    valid_d  = 1'b0;
    pend_d   = pend_q;
    depth_d  = depth_q;
    rep_d    = rep_q;

    case (state_q)
      S_IDLE: begin
        audio_d = 16'd0;
        pend_d  = 1'b0;
        if (ev_code_s != 4'd0) begin
          state_d  = S_START;
          select_d = ev_code_s;
          adr_d    = 18'd0;
        end else if (music_en) begin
          state_d  = S_START;
          select_d = ST_SEL;
          adr_d    = saved_q;
        end else begin
          select_d = 4'd0;
          adr_d    = 18'd0;
        end
      end
      S_START: begin
        pend_d = pend_q | sample_tick;
        if (cnt_q == LAT_CNT) begin
          depth_d = depth;
          rep_d   = (repeats != 32'd0);
          if (depth == 18'd0) begin
            state_d  = S_END;
            select_d = 4'd0;
          end else begin
            state_d = S_READY;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_READY: begin
        if (sample_tick || pend_q) begin
          pend_d  = 1'b0;
          audio_d = dout;
          valid_d = 1'b1;
          if (adr_inc_s == depth_q) begin
            // The soundtrack loops no matter what its repeat word says.
            if (rep_q || (select_q == ST_SEL)) begin
              adr_d   = 18'd0;
              state_d = S_SETTLE;
            end else begin
              state_d  = S_END;
              select_d = 4'd0;
            end
          end else begin
            adr_d   = adr_inc_s;
            state_d = S_SETTLE;
          end
        end else begin
          state_d = S_READY;
        end
      end
      S_SETTLE: begin
        pend_d = pend_q | sample_tick;
        if (cnt_q == LAT_CNT) begin
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_END: begin
        pend_d = 1'b0;
        if (ev_code_s != 4'd0) begin
          state_d  = S_START;
          select_d = ev_code_s;
          adr_d    = 18'd0;
        end else if (music_en) begin
          state_d  = S_START;
          select_d = ST_SEL;
          adr_d    = saved_q;
        end else begin
          state_d  = S_IDLE;
          select_d = 4'd0;
          adr_d    = 18'd0;
          audio_d  = 16'd0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        select_d = 4'd0;
        adr_d    = 18'd0;
        audio_d  = 16'd0;
        pend_d   = 1'b0;
      end
    endcase

    if (playing_s) begin
      if (preempt_s) begin
        // Remember where the soundtrack was so it can pick up from there.
        saved_d  = (select_q == ST_SEL) ? adr_q : saved_q;
        state_d  = S_START;
        select_d = ev_code_s;
        adr_d    = 18'd0;
        cnt_d    = 8'd0;
        audio_d  = audio_q;
        valid_d  = 1'b0;
        pend_d   = pend_q;
      end else if ((select_q == ST_SEL) && !music_en) begin
        saved_d  = adr_q;
        state_d  = S_IDLE;
        select_d = 4'd0;
        adr_d    = 18'd0;
        cnt_d    = 8'd0;
        audio_d  = 16'd0;
        valid_d  = 1'b0;
        pend_d   = 1'b0;
      end else begin
        saved_d = saved_q;
      end
    end else begin
      saved_d = saved_q;
    end

    busy_d = (select_d != 4'd0);
  end

  // State and output registers, cleared asynchronously by the active-high reset.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      select_q <= 4'd0;
      adr_q    <= 18'd0;
      saved_q  <= 18'd0;
      audio_q  <= 16'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      pend_q   <= 1'b0;
      depth_q  <= 18'd0;
      rep_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      select_q <= select_d;
      adr_q    <= adr_d;
      saved_q  <= saved_d;
      audio_q  <= audio_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      depth_q  <= depth_d;
      rep_q    <= rep_d;
    end
  end

  assign select      = select_q;
  assign adress      = {14'd0, adr_q};
  assign audio_out   = audio_q;
  assign audio_valid = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer. A two-stage ROM model returns
// dout = {select, adress[11:0]}, so every sample identifies its track and word.
module tb_sound_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sample_tick;
  logic        ev_player_hit, ev_shot, ev_invader, ev_ufo;
  logic        music_en;
  logic [3:0]  select;
  logic [31:0] adress;
  logic [15:0] dout;
  logic [17:0] depth;
  logic [31:0] repeats;
  logic [15:0] audio_out;
  logic        audio_valid;
  logic        busy;

  logic [17:0] dep_tab [16];
  logic [31:0] rep_tab [16];
  logic [15:0] s1_dout;
  logic [17:0] s1_depth;
  logic [31:0] s1_rep;

  int total = 0;
  int bad   = 0;
  int nval;
  logic [15:0] smp;

  sound_sequencer #(.ROM_LATENCY(2), .SOUNDTRACK_SEL(5)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .sample_tick  (sample_tick),
    .ev_player_hit(ev_player_hit),
    .ev_shot      (ev_shot),
    .ev_invader   (ev_invader),
    .ev_ufo       (ev_ufo),
    .music_en     (music_en),
    .select       (select),
    .adress       (adress),
    .dout         (dout),
    .depth        (depth),
    .repeats      (repeats),
    .audio_out    (audio_out),
    .audio_valid  (audio_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // ROM mux model with two cycles of latency.
  always @(posedge clk) begin
    s1_dout  <= {select, adress[11:0]};
    s1_depth <= dep_tab[select];
    s1_rep   <= rep_tab[select];
    dout     <= s1_dout;
    depth    <= s1_depth;
    repeats  <= s1_rep;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse events for one cycle; mask bits = {ufo, invader, shot, player_hit}.
  task automatic pulse_ev(input logic [3:0] m);
    ev_player_hit = m[0];
    ev_shot       = m[1];
    ev_invader    = m[2];
    ev_ufo        = m[3];
    @(negedge clk);
    ev_player_hit = 1'b0;
    ev_shot       = 1'b0;
    ev_invader    = 1'b0;
    ev_ufo        = 1'b0;
  endtask

  // One sample tick, then watch 16 cycles for strobes and capture the sample.
  task automatic tick16(output int n, output logic [15:0] s);
    n = 0;
    s = 16'h0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (audio_valid) begin
        n++;
        s = audio_out;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      dep_tab[i] = 18'd4;
      rep_tab[i] = 32'd0;
    end
    resetN = 1'b1;
    sample_tick = 1'b0;
    ev_player_hit = 1'b0; ev_shot = 1'b0; ev_invader = 1'b0; ev_ufo = 1'b0;
    music_en = 1'b0;
    repeat (3) @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_select", 32'(select), 32'd0);
    check_eq("rst_audio", 32'(audio_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(audio_valid), 32'd0);

    // One-shot shot effect, depth 4, no repeat
    dep_tab[2] = 18'd4; rep_tab[2] = 32'd0;
    pulse_ev(4'b0010);
    check_eq("shot_select", 32'(select), 32'd2);
    check_eq("shot_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick16(nval, smp);
      check_eq("shot_nvalid", 32'(nval), 32'd1);
      check_eq("shot_sample", 32'(smp), 32'h2000 + 32'(k));
    end
    check_eq("shot_end_select", 32'(select), 32'd0);
    check_eq("shot_end_busy", 32'(busy), 32'd0);

    // Soundtrack loops over depth 3 even with repeats = 0
    dep_tab[5] = 18'd3; rep_tab[5] = 32'd0;
    music_en = 1'b1;
    @(negedge clk);
    check_eq("st_select", 32'(select), 32'd5);
    for (int k = 0; k < 5; k++) begin
      tick16(nval, smp);
      check_eq("st_nvalid", 32'(nval), 32'd1);
      check_eq("st_sample", 32'(smp), 32'h5000 + 32'(k % 3));
      check_eq("st_select_hold", 32'(select), 32'd5);
    end

    // Music off stores address 2; re-enable resumes there
    music_en = 1'b0;
    @(negedge clk);
    check_eq("mute_select", 32'(select), 32'd0);
    check_eq("mute_audio", 32'(audio_out), 32'd0);
    dep_tab[5] = 18'd10;
    music_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      tick16(nval, smp);
      check_eq("resume_sample", 32'(smp), 32'h5002 + 32'(k));
    end

    // Invader preempts soundtrack at address 7, soundtrack resumes at 7
    dep_tab[3] = 18'd2; rep_tab[3] = 32'd0;
    pulse_ev(4'b0100);
    check_eq("inv_select", 32'(select), 32'd3);
    for (int k = 0; k < 2; k++) begin
      tick16(nval, smp);
      check_eq("inv_sample", 32'(smp), 32'h3000 + 32'(k));
    end
    check_eq("inv_back_select", 32'(select), 32'd5);
    tick16(nval, smp);
    check_eq("inv_back_sample", 32'(smp), 32'h5007);

    // Priority chain: ufo, then shot preempts, ufo dropped, hit+shot -> hit
    dep_tab[4] = 18'd6; rep_tab[4] = 32'd1;
    pulse_ev(4'b1000);
    check_eq("ufo_select", 32'(select), 32'd4);
    tick16(nval, smp);
    check_eq("ufo_sample", 32'(smp), 32'h4000);
    pulse_ev(4'b0010);
    check_eq("shot_over_ufo", 32'(select), 32'd2);
    tick16(nval, smp);
    check_eq("shot_over_ufo_smp", 32'(smp), 32'h2000);
    pulse_ev(4'b1000);
    check_eq("ufo_dropped", 32'(select), 32'd2);
    tick16(nval, smp);
    check_eq("shot_continues", 32'(smp), 32'h2001);
    dep_tab[1] = 18'd3; rep_tab[1] = 32'd0;
    pulse_ev(4'b0011);
    check_eq("hit_wins", 32'(select), 32'd1);
    tick16(nval, smp);
    check_eq("hit_sample", 32'(smp), 32'h1000);

    // Asynchronous reset mid-track, between clock edges
    #2 resetN = 1'b1;
    #1;
    check_eq("arst_select", 32'(select), 32'd0);
    check_eq("arst_audio", 32'(audio_out), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_adress", adress, 32'd0);
    #5 resetN = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("arst_st_select", 32'(select), 32'd5);
    tick16(nval, smp);
    check_eq("arst_saved_zero", 32'(smp), 32'h5000);

    // Zero-depth track produces no sample and falls back to the soundtrack
    dep_tab[4] = 18'd0;
    pulse_ev(4'b1000);
    check_eq("d0_select", 32'(select), 32'd4);
    tick16(nval, smp);
    check_eq("d0_nvalid", 32'(nval), 32'd0);
    check_eq("d0_back_select", 32'(select), 32'd5);
    tick16(nval, smp);
    check_eq("d0_back_sample", 32'(smp), 32'h5001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Drives the audio track ROM mux from game events and delivers one 16-bit PCM sample per codec sample tick.
- Upstream: game-event pulses and a music-enable level. Downstream of the ROM mux, it drives select/adress and consumes dout/depth/repeats.
- Output goes to the audio codec serializer.
- Arbitrates one-shot effects over the looping soundtrack, and resumes the soundtrack where it was interrupted.

Parameters:
ROM_LATENCY, 2, clk cycles from a select/adress change to valid dout/depth/repeats.
SOUNDTRACK_SEL, 5, select code of the looping background track.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous reset, active-high (1 = reset)
sample_tick  in  1  one-cycle pulse per codec sample period
ev_player_hit  in  1  one-cycle event pulse, select code 1
ev_shot  in  1  one-cycle event pulse, select code 2
ev_invader  in  1  one-cycle event pulse, select code 3
ev_ufo  in  1  one-cycle event pulse, select code 4
music_en  in  1  level; soundtrack allowed when 1
select  out  4  track select to ROM mux; 0 = silence
adress  out  32  word index within the selected track
dout  in  16  sample word from ROM mux
depth  in  18  track length in words
repeats  in  32  0 = play once, nonzero = loop
audio_out  out  16  current sample to codec
audio_valid  out  1  one-cycle strobe when audio_out updates
busy  out  1  1 whenever select != 0

Behaviour:
- Reset (asynchronous, any state) clears all of the following to 0: select, adress, audio_out, audio_valid, busy, saved soundtrack address, pending-tick flag. State goes to IDLE.
- Priority, high to low: player_hit(1), invader(3), shot(2), ufo(4), soundtrack.
- If several events pulse in the same cycle, the highest priority wins and the others are dropped.
- States:
  - IDLE: select=0, audio_out held at 0. On any event: START with that code. Else if music_en: START with SOUNDTRACK_SEL, using the saved address.
  - START: drive select and start adress, then wait ROM_LATENCY cycles. Then latch depth_r and repeats_r and go to READY. If depth_r == 0, go to END instead.
  - READY: wait for sample_tick or a pending tick. On the tick:
    - audio_out <= dout; audio_valid = 1 for exactly one cycle.
    - Advance: if adress[17:0]+1 == depth_r, adress wraps to 0 when repeats_r != 0, otherwise go to END. Else adress+1.
    - Then go to SETTLE.
  - SETTLE: wait ROM_LATENCY cycles, then go to READY.
  - END: one-shot finished. If music_en, START the soundtrack from the saved address; else go to IDLE with audio_out = 0.
- Preemption: an event of strictly higher priority than the current track goes to START on the next cycle, regardless of state.
  - If the current track is the soundtrack, its adress is stored first.
  - An event of equal code restarts that track at address 0.
  - Events of lower priority are dropped.
  - Any event preempts the soundtrack.
- music_en falling while the soundtrack plays: store adress, go to IDLE next cycle.
- The soundtrack always loops regardless of repeats.
- A sample_tick arriving in START or SETTLE sets the one-deep pending flag; READY consumes it on entry. A second tick while pending is already set is lost.
- Minimum tick spacing is ROM_LATENCY+3 cycles.
- audio_out holds its last value between ticks.
- The upper 14 bits of adress are always 0.

Test Plan:
- Reset with music_en=0 → select=0, audio_out=0, busy=0, no audio_valid.
- ev_shot, depth=4, repeats=0, ticks every 16 cycles → 4 audio_valid strobes with dout at adress 0,1,2,3; then select=0, busy=0.
- music_en=1, soundtrack depth=3 → adress sequence 0,1,2,0,1 across 5 ticks; select=5 throughout.
- Soundtrack at adress 7, then ev_invader (depth=2, repeats=0) → select=3 next cycle; after 2 samples select=5, resuming at adress 7.
- ev_ufo playing, then ev_shot → select=2 from adress 0. Then ev_ufo during shot → ignored. ev_player_hit and ev_shot in the same cycle → select=1.
- Mid-track, resetN pulsed high for 1 cycle (asynchronous, between clock edges) → outputs 0 immediately; saved address=0; IDLE.
- Track with depth=0 → no audio_valid; falls straight to END.
